// File: rtl/dmni_hermes_cmd_queue.sv
// dmni_hermes_cmd_queue
// Descriptor FIFO plus single-outstanding sequencer for the DMNI Hermes engine.
// The head descriptor is issued with a one-cycle start pulse, and the queue then
// tracks the matching engine active flag until the transfer completes.
// The operation type (hermes_op_t) is carried as a 1-bit logic: 0 = SEND, 1 = RECEIVE.
// Optional start watchdog: define DMNI_CMDQ_TIMEOUT_EN.
module dmni_hermes_cmd_queue #(
    parameter int DEPTH          = 4,
    parameter int TIMEOUT_CYCLES = 16
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    output logic                     push_ready_o,
    input  logic                     push_op_i,
    input  logic [31:0]              push_size_i,
    input  logic [31:0]              push_size_2_i,
    input  logic [31:0]              push_address_i,
    input  logic [31:0]              push_address_2_i,
    input  logic                     flush_i,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     busy_o,
    output logic                     done_o,
    output logic                     done_op_o,
    output logic                     timeout_o,
    input  logic                     hermes_send_active_i,
    input  logic                     hermes_receive_active_i,
    output logic                     hermes_start_o,
    output logic                     hermes_operation_o,
    output logic [31:0]              hermes_size_o,
    output logic [31:0]              hermes_size_2_o,
    output logic [31:0]              hermes_address_o,
    output logic [31:0]              hermes_address_2_o
);

    localparam int PTR_W = $clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;
    localparam logic [PTR_W-1:0] PTR_ONE = PTR_W'(1);
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);
    localparam logic HERMES_OPERATION_SEND = 1'b0;

    if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_depth_check
        $error("DEPTH must be a power of two and at least 2");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 256) begin : g_timeout_check
        $error("TIMEOUT_CYCLES must fit the 8-bit watchdog (1..256)");
    end

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        WAIT_START = 2'd1,
        WAIT_DONE  = 2'd2
    } state_t;

    state_t             state_q, state_d;
    logic [PTR_W-1:0]   head_q, tail_q;
    logic [CNT_W-1:0]   count_q;
    logic               do_push;
    logic               issue;
    logic               done_d;
    logic               sel_active;

    logic               op_mem    [DEPTH];
    logic [31:0]        size_mem  [DEPTH];
    logic [31:0]        size2_mem [DEPTH];
    logic [31:0]        addr_mem  [DEPTH];
    logic [31:0]        addr2_mem [DEPTH];

    assign count_o      = count_q;
    assign push_ready_o = (count_q < CNT_W'(DEPTH));
    // A flush in the same cycle wins over the push.
    assign do_push      = push_i && push_ready_o && !flush_i;
    assign sel_active   = (hermes_operation_o == HERMES_OPERATION_SEND) ?
                          hermes_send_active_i : hermes_receive_active_i;

`ifdef DMNI_CMDQ_TIMEOUT_EN
    logic [7:0] wd_q;
    logic       wd_expired;
    logic       timeout_d;

    assign wd_expired = (wd_q == 8'(TIMEOUT_CYCLES - 1));

    // Watchdog: cleared on issue, counts every cycle spent waiting for active.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wd_q <= '0;
        end else if (issue) begin
            wd_q <= '0;
        end else if (state_q == WAIT_START) begin
            wd_q <= wd_q + 8'd1;
        end
    end

    // Registered watchdog expiry pulse.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            timeout_o <= 1'b0;
        end else begin
            timeout_o <= timeout_d;
        end
    end
`else
    assign timeout_o = 1'b0;
`endif

    // Sequencer state register.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state decode: issue from IDLE, wait for active to rise, then to fall.
    always_comb begin
        state_d = state_q;
        issue   = 1'b0;
        done_d  = 1'b0;
`ifdef DMNI_CMDQ_TIMEOUT_EN
        timeout_d = 1'b0;
`endif
        case (state_q)
            IDLE: begin
                if (count_q != '0 && !flush_i) begin
                    issue   = 1'b1;
                    state_d = WAIT_START;
                end
            end
            WAIT_START: begin
                if (sel_active) begin
                    state_d = WAIT_DONE;
                end
`ifdef DMNI_CMDQ_TIMEOUT_EN
                else if (wd_expired) begin
                    timeout_d = 1'b1;
                    state_d   = IDLE;
                end
`endif
            end
            WAIT_DONE: begin
                if (!sel_active) begin
                    done_d  = 1'b1;
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    // Queue pointers and occupancy; flush empties the queue but leaves any in-flight transfer alone.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            head_q  <= tail_q;
            count_q <= '0;
        end else begin
            if (do_push) tail_q <= tail_q + PTR_ONE;
            if (issue)   head_q <= head_q + PTR_ONE;
            if (do_push && !issue) begin
                count_q <= count_q + CNT_ONE;
            end else if (!do_push && issue) begin
                count_q <= count_q - CNT_ONE;
            end
        end
    end

    // Descriptor storage, written at the tail on an accepted push.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            op_mem[tail_q]    <= push_op_i;
            size_mem[tail_q]  <= push_size_i;
            size2_mem[tail_q] <= push_size_2_i;
            addr_mem[tail_q]  <= push_address_i;
            addr2_mem[tail_q] <= push_address_2_i;
        end
    end

    // Engine-facing and status outputs; descriptor fields hold until the next issue.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            hermes_start_o     <= 1'b0;
            hermes_operation_o <= HERMES_OPERATION_SEND;
            hermes_size_o      <= '0;
            hermes_size_2_o    <= '0;
            hermes_address_o   <= '0;
            hermes_address_2_o <= '0;
            done_o             <= 1'b0;
            done_op_o          <= HERMES_OPERATION_SEND;
            busy_o             <= 1'b0;
        end else begin
            hermes_start_o <= issue;
            done_o         <= done_d;
            busy_o         <= (state_d != IDLE);
            if (issue) begin
                hermes_operation_o <= op_mem[head_q];
                hermes_size_o      <= size_mem[head_q];
                hermes_size_2_o    <= size2_mem[head_q];
                hermes_address_o   <= addr_mem[head_q];
                hermes_address_2_o <= addr2_mem[head_q];
            end
            if (done_d) begin
                done_op_o <= hermes_operation_o;
            end
        end
    end

endmodule

// File: tb/tb_dmni_hermes_cmd_queue.sv
// tb_dmni_hermes_cmd_queue
// Scoreboard bench: a queue-based reference model predicts issues, completions,
// timeouts and occupancy; a monitor on the falling edge compares against the DUT.
module tb_dmni_hermes_cmd_queue;

    localparam int   DEPTH          = 4;
    localparam int   TIMEOUT_CYCLES = 16;
    localparam logic OP_SEND        = 1'b0;
    localparam logic OP_RECV        = 1'b1;

    logic        clk_i = 1'b0;
    logic        rst_ni = 1'b0;
    logic        push_i = 1'b0;
    logic        push_op_i = 1'b0;
    logic [31:0] push_size_i = '0, push_size_2_i = '0, push_address_i = '0, push_address_2_i = '0;
    logic        flush_i = 1'b0;
    logic        send_act = 1'b0, recv_act = 1'b0;

    logic                  push_ready_o, busy_o, done_o, done_op_o, timeout_o;
    logic [$clog2(DEPTH):0] count_o;
    logic                  hermes_start_o, hermes_operation_o;
    logic [31:0]           hermes_size_o, hermes_size_2_o, hermes_address_o, hermes_address_2_o;

    dmni_hermes_cmd_queue #(.DEPTH(DEPTH), .TIMEOUT_CYCLES(TIMEOUT_CYCLES)) dut (
        .clk_i                  (clk_i),
        .rst_ni                 (rst_ni),
        .push_i                 (push_i),
        .push_ready_o           (push_ready_o),
        .push_op_i              (push_op_i),
        .push_size_i            (push_size_i),
        .push_size_2_i          (push_size_2_i),
        .push_address_i         (push_address_i),
        .push_address_2_i       (push_address_2_i),
        .flush_i                (flush_i),
        .count_o                (count_o),
        .busy_o                 (busy_o),
        .done_o                 (done_o),
        .done_op_o              (done_op_o),
        .timeout_o              (timeout_o),
        .hermes_send_active_i   (send_act),
        .hermes_receive_active_i(recv_act),
        .hermes_start_o         (hermes_start_o),
        .hermes_operation_o     (hermes_operation_o),
        .hermes_size_o          (hermes_size_o),
        .hermes_size_2_o        (hermes_size_2_o),
        .hermes_address_o       (hermes_address_o),
        .hermes_address_2_o     (hermes_address_2_o)
    );

    always #5 clk_i = ~clk_i;

    typedef struct {
        logic        op;
        logic [31:0] size, size2, addr, addr2;
        int          cyc;
    } desc_t;

    typedef struct {
        logic op;
        int   cyc;
    } evt_t;

    desc_t mq[$];
    desc_t exp_issue[$];
    evt_t  exp_done[$];
    int    exp_to[$];

    int   cyc = 0;
    bit   inflight = 0, saw_active = 0;
    logic m_op = OP_SEND;
    int   wait_cnt = 0;

    int tests = 0;
    int fails = 0;

    int eng_delay = 0, eng_len = 0;
    bit stall = 0, eng_busy = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // Reference model: one step per clock edge, from the pre-edge inputs.
    always @(posedge clk_i or negedge rst_ni) begin : ref_model
        bit    accept;
        logic  sel;
        desc_t d;
        if (!rst_ni) begin
            mq.delete();
            exp_issue.delete();
            exp_done.delete();
            exp_to.delete();
            inflight   = 0;
            saw_active = 0;
            wait_cnt   = 0;
        end else begin
            cyc++;
            accept = push_i && !flush_i && (mq.size() < DEPTH);
            if (inflight) begin
                sel = (m_op == OP_SEND) ? send_act : recv_act;
                if (!saw_active) begin
                    if (sel) begin
                        saw_active = 1;
                    end else begin
                        wait_cnt++;
`ifdef DMNI_CMDQ_TIMEOUT_EN
                        if (wait_cnt == TIMEOUT_CYCLES) begin
                            exp_to.push_back(cyc);
                            inflight = 0;
                        end
`endif
                    end
                end else if (!sel) begin
                    exp_done.push_back('{op: m_op, cyc: cyc});
                    inflight = 0;
                end
            end else if (mq.size() > 0 && !flush_i) begin
                d          = mq.pop_front();
                d.cyc      = cyc;
                exp_issue.push_back(d);
                m_op       = d.op;
                inflight   = 1;
                saw_active = 0;
                wait_cnt   = 0;
            end
            if (flush_i) mq.delete();
            if (accept) begin
                d.op    = push_op_i;
                d.size  = push_size_i;
                d.size2 = push_size_2_i;
                d.addr  = push_address_i;
                d.addr2 = push_address_2_i;
                d.cyc   = 0;
                mq.push_back(d);
            end
        end
    end

    // Monitor: compares DUT outputs to the model on the falling edge.
    always @(negedge clk_i) begin : monitor
        desc_t e;
        evt_t  dn;
        int    t;
        chk("count", 64'(count_o), 64'(mq.size()));
        chk("push_ready", 64'(push_ready_o), 64'(mq.size() < DEPTH));
        chk("busy", 64'(busy_o), 64'(inflight));

        if (exp_issue.size() > 0 && exp_issue[0].cyc < cyc) begin
            e = exp_issue.pop_front();
            tests++; fails++;
            $display("FAIL start_missing: no start seen, expected one in cycle %0d", e.cyc);
        end
        if (hermes_start_o) begin
            if (exp_issue.size() == 0) begin
                tests++; fails++;
                $display("FAIL start_unexpected: start=1 in cycle %0d, expected 0", cyc);
            end else begin
                e = exp_issue.pop_front();
                chk("start_cycle", 64'(cyc), 64'(e.cyc));
                chk("issue_op", 64'(hermes_operation_o), 64'(e.op));
                chk("issue_size", 64'(hermes_size_o), 64'(e.size));
                chk("issue_size_2", 64'(hermes_size_2_o), 64'(e.size2));
                chk("issue_addr", 64'(hermes_address_o), 64'(e.addr));
                chk("issue_addr_2", 64'(hermes_address_2_o), 64'(e.addr2));
            end
        end

        if (exp_done.size() > 0 && exp_done[0].cyc < cyc) begin
            dn = exp_done.pop_front();
            tests++; fails++;
            $display("FAIL done_missing: no done seen, expected one in cycle %0d", dn.cyc);
        end
        if (done_o) begin
            if (exp_done.size() == 0) begin
                tests++; fails++;
                $display("FAIL done_unexpected: done=1 in cycle %0d, expected 0", cyc);
            end else begin
                dn = exp_done.pop_front();
                chk("done_cycle", 64'(cyc), 64'(dn.cyc));
                chk("done_op", 64'(done_op_o), 64'(dn.op));
            end
        end

        if (exp_to.size() > 0 && exp_to[0] < cyc) begin
            t = exp_to.pop_front();
            tests++; fails++;
            $display("FAIL timeout_missing: no timeout seen, expected one in cycle %0d", t);
        end
        if (timeout_o) begin
            if (exp_to.size() == 0) begin
                tests++; fails++;
                $display("FAIL timeout_unexpected: timeout=1 in cycle %0d, expected 0", cyc);
            end else begin
                t = exp_to.pop_front();
                chk("timeout_cycle", 64'(cyc), 64'(t));
            end
        end
    end

    // Engine responder: raises the matching active flag some cycles after start, holds it, drops it.
    initial begin : engine
        logic op;
        int   d, l;
        forever begin
            @(posedge clk_i); #1;
            if (rst_ni && hermes_start_o) begin
                eng_busy = 1;
                op = hermes_operation_o;
                d  = (eng_delay > 0) ? eng_delay : int'($urandom_range(1, 3));
                l  = (eng_len > 0) ? eng_len : int'($urandom_range(1, 6));
                while (stall) begin
                    @(posedge clk_i); #1;
                end
                repeat (d) @(posedge clk_i);
                #1;
                if (op == OP_SEND) send_act = 1'b1; else recv_act = 1'b1;
                repeat (l) @(posedge clk_i);
                #1;
                send_act = 1'b0;
                recv_act = 1'b0;
                eng_busy = 0;
            end
        end
    end

    task automatic push(input logic op, input logic [31:0] s, input logic [31:0] s2,
                        input logic [31:0] a, input logic [31:0] a2);
        push_i = 1'b1; push_op_i = op;
        push_size_i = s; push_size_2_i = s2; push_address_i = a; push_address_2_i = a2;
        @(posedge clk_i); #1;
        push_i = 1'b0;
    endtask

    task automatic wait_idle(input string name, input int budget);
        int n = 0;
        while ((busy_o || count_o != 0 || eng_busy || send_act || recv_act) && n < budget) begin
            @(posedge clk_i); #1;
            n++;
        end
        tests++;
        if (n >= budget) begin
            fails++;
            $display("FAIL %s: still busy after %0d cycles, expected idle", name, budget);
        end
        repeat (2) @(posedge clk_i);
        #1;
    endtask

    task automatic chk_reset_values(input string tag);
        chk({tag, "_start"}, 64'(hermes_start_o), 64'(0));
        chk({tag, "_op"}, 64'(hermes_operation_o), 64'(OP_SEND));
        chk({tag, "_size"}, 64'(hermes_size_o), 64'(0));
        chk({tag, "_size_2"}, 64'(hermes_size_2_o), 64'(0));
        chk({tag, "_addr"}, 64'(hermes_address_o), 64'(0));
        chk({tag, "_addr_2"}, 64'(hermes_address_2_o), 64'(0));
        chk({tag, "_done"}, 64'(done_o), 64'(0));
        chk({tag, "_timeout"}, 64'(timeout_o), 64'(0));
        chk({tag, "_busy"}, 64'(busy_o), 64'(0));
        chk({tag, "_count"}, 64'(count_o), 64'(0));
        chk({tag, "_ready"}, 64'(push_ready_o), 64'(1));
    endtask

    initial begin : guard
        #500000;
        $display("FAIL global_timeout: simulation did not finish, expected completion");
        $fatal(1, "time limit reached");
    end

    initial begin : stimulus
        int n;
        repeat (3) @(posedge clk_i);
        #1;
        chk_reset_values("por");
        rst_ni = 1'b1;
        repeat (2) @(posedge clk_i);
        #1;

        // Single SEND transfer with a fixed engine response.
        eng_delay = 2; eng_len = 5;
        push(OP_SEND, 32'h10, 32'h0, 32'h1000, 32'h0);
        wait_idle("single_send", 60);
        chk("single_send_busy", 64'(busy_o), 64'(0));

        // Fill the queue behind a stalled transfer.
        eng_delay = 0; eng_len = 0;
        stall = 1;
        push(OP_RECV, 32'h1, 32'h2, 32'h3, 32'h4);
        repeat (2) @(posedge clk_i);
        #1;
        for (int i = 0; i < 5; i++) begin
            push(logic'(i[0]), 32'h100 + i, 32'h200 + i, 32'h300 + i, 32'h400 + i);
        end
        chk("full_count", 64'(count_o), 64'(DEPTH));
        chk("full_ready", 64'(push_ready_o), 64'(0));

        // Hold a push while full; the pop edge must not also accept it.
        push_i = 1'b1; push_op_i = OP_SEND;
        push_size_i = 32'hAAAA; push_size_2_i = 32'hBBBB;
        push_address_i = 32'hCCCC; push_address_2_i = 32'hDDDD;
        stall = 0;
        n = 0;
        while (count_o != 3 && n < 60) begin
            @(posedge clk_i); #1;
            n++;
        end
        push_i = 1'b0;
        chk("full_pop_count", 64'(count_o), 64'(3));
        wait_idle("full_drain", 300);

        // Flush during the first of three RECEIVE transfers.
        eng_delay = 2; eng_len = 6;
        push(OP_RECV, 32'h20, 32'h21, 32'h2200, 32'h2300);
        push(OP_RECV, 32'h30, 32'h31, 32'h3200, 32'h3300);
        push(OP_RECV, 32'h40, 32'h41, 32'h4200, 32'h4300);
        n = 0;
        while (!recv_act && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        flush_i = 1'b1;
        @(posedge clk_i); #1;
        flush_i = 1'b0;
        chk("flush_count", 64'(count_o), 64'(0));
        chk("flush_busy", 64'(busy_o), 64'(1));
        wait_idle("flush", 60);

`ifdef DMNI_CMDQ_TIMEOUT_EN
        // Engine never responds: each issue times out, the next one follows.
        stall = 1;
        push(OP_SEND, 32'h50, 32'h51, 32'h5200, 32'h5300);
        push(OP_SEND, 32'h60, 32'h61, 32'h6200, 32'h6300);
        repeat (2 * TIMEOUT_CYCLES + 8) @(posedge clk_i);
        #1;
        stall = 0;
        wait_idle("timeout", 100);
`endif

        // Randomized traffic with occasional flushes.
        eng_delay = 0; eng_len = 0;
        for (int i = 0; i < 200; i++) begin
            push_i           = ($urandom_range(0, 1) == 1);
            push_op_i        = logic'($urandom_range(0, 1));
            push_size_i      = $urandom;
            push_size_2_i    = $urandom;
            push_address_i   = $urandom;
            push_address_2_i = $urandom;
            flush_i          = ($urandom_range(0, 24) == 0);
            @(posedge clk_i); #1;
        end
        push_i = 1'b0;
        flush_i = 1'b0;
        wait_idle("random", 600);

        // Asynchronous reset while a transfer is in WAIT_DONE with one entry queued.
        eng_delay = 1; eng_len = 12;
        push(OP_RECV, 32'hABC, 32'h5, 32'h2000, 32'h3000);
        push(OP_SEND, 32'hDEF, 32'h6, 32'h4000, 32'h5000);
        n = 0;
        while (!recv_act && n < 20) begin
            @(posedge clk_i); #1;
            n++;
        end
        repeat (2) @(posedge clk_i);
        #3;
        rst_ni = 1'b0;
        #1;
        chk_reset_values("mid_reset");
        repeat (2) @(posedge clk_i);
        #1;
        rst_ni = 1'b1;
        repeat (20) @(posedge clk_i);
        #1;
        chk("post_reset_count", 64'(count_o), 64'(0));
        wait_idle("post_reset", 60);

        chk("pending_issue", 64'(exp_issue.size()), 64'(0));
        chk("pending_done", 64'(exp_done.size()), 64'(0));
        chk("pending_timeout", 64'(exp_to.size()), 64'(0));

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
